// File: rtl/bram_pkg.sv
// Shared definitions for the simple-dual-port byte-enable RAM.
//   RDW_READ_FIRST / RDW_WRITE_FIRST : same-word collision policies
//   bram_aw(dw, wl)    : byte-address width for a dw-bit, wl-word RAM
//   bram_widx(addr,bw) : word index of a byte address (bw bytes per word)
package bram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int bram_aw(input int dw, input int wl);
    return $clog2(wl) + $clog2(dw / 8);
  endfunction

  // Byte offset inside a word is simply dropped; callers truncate the
  // result to their own word-index width.
  function automatic logic [31:0] bram_widx(input logic [31:0] addr, input int bw);
    return addr >> $clog2(bw);
  endfunction

endpackage

// File: rtl/bram_be_merge.sv
// Combinational byte-lane merge: each lane takes the new data when its
// enable bit is set, otherwise keeps the old word's byte.
//   old_word in  DW : current memory word
//   di       in  DW : write data
//   we       in  BW : byte enables, bit i covers di[8i+7:8i]
//   merged   out DW : resulting word
module bram_be_merge #(
  parameter int DW = 128,
  localparam int BW = DW / 8
) (
  input  logic [DW-1:0] old_word,
  input  logic [DW-1:0] di,
  input  logic [BW-1:0] we,
  output logic [DW-1:0] merged
);

  for (genvar gi = 0; gi < BW; gi++) begin : g_lane
    assign merged[8*gi +: 8] = we[gi] ? di[8*gi +: 8] : old_word[8*gi +: 8];
  end

endmodule

// File: rtl/bram_sdp_be.sv
// Simple-dual-port behavioural RAM with per-byte write enables,
// selectable read-during-write policy and a read-valid strobe.
// Optional macro BRAM_SDP_BE_OUT_REG_EN adds an output register stage
// (read latency 2 instead of 1).
//   CLK in  1  : clock
//   RST in  1  : synchronous active-high reset (clears read pipe, not RAM)
//   WEN in  1  : write enable          WE in BW : byte write mask
//   WA  in  AW : write byte address    Di in DW : write data
//   REN in  1  : read enable           RA in AW : read byte address
//   Do  out DW : read data (holds until next read completes)
//   DoV out 1  : one-cycle strobe for new data on Do
module bram_sdp_be
  import bram_pkg::*;
#(
  parameter int DW       = 128,
  parameter int WL       = 1024,
  parameter int RDW_MODE = RDW_READ_FIRST,
  parameter     INIT_FILE = "",
  localparam int BW = DW / 8,
  localparam int AW = bram_aw(DW, WL)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WEN,
  input  logic [BW-1:0] WE,
  input  logic [AW-1:0] WA,
  input  logic [DW-1:0] Di,
  input  logic          REN,
  input  logic [AW-1:0] RA,
  output logic [DW-1:0] Do,
  output logic          DoV
);

  localparam int        IW   = $clog2(WL);
  localparam logic [IW:0] WL_W = (IW + 1)'(WL);

  logic [DW-1:0] mem [WL];

  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          wr_ok;
  logic          rd_ok;
  logic          collide;
  logic [DW-1:0] wr_merged;
  logic [DW-1:0] byp_merged;
  logic [DW-1:0] rd_word;
  logic          rd_vld_reg;
  logic [DW-1:0] rd_data_reg;

  assign wr_idx = IW'(bram_widx(32'(WA), BW));
  assign rd_idx = IW'(bram_widx(32'(RA), BW));

  // Only matters when WL is not a power of two.
  assign wr_ok = {1'b0, wr_idx} < WL_W;
  assign rd_ok = {1'b0, rd_idx} < WL_W;

  // Write path: read-modify-write so disabled lanes keep their bytes.
  bram_be_merge #(.DW(DW)) u_wr_merge (
    .old_word (mem[wr_idx]),
    .di       (Di),
    .we       (WE),
    .merged   (wr_merged)
  );

  always_ff @(posedge CLK) begin
    if (!RST && WEN && wr_ok)
      mem[wr_idx] <= wr_merged;
  end

  // Write-first bypass: the word the read would see after this edge's write.
  bram_be_merge #(.DW(DW)) u_byp_merge (
    .old_word (mem[rd_idx]),
    .di       (Di),
    .we       (WE),
    .merged   (byp_merged)
  );

  assign collide = WEN && (wr_idx == rd_idx);

  always_comb begin
    rd_word = mem[rd_idx];
    if (!rd_ok)
      rd_word = '0;
    else if (RDW_MODE == RDW_WRITE_FIRST && collide)
      rd_word = byp_merged;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_vld_reg  <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rd_vld_reg <= REN;
      if (REN)
        rd_data_reg <= rd_word;
    end
  end

`ifdef BRAM_SDP_BE_OUT_REG_EN
  logic          out_vld_reg;
  logic [DW-1:0] out_data_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
    end else begin
      out_vld_reg <= rd_vld_reg;
      if (rd_vld_reg)
        out_data_reg <= rd_data_reg;
    end
  end

  assign Do  = out_data_reg;
  assign DoV = out_vld_reg;
`else
  assign Do  = rd_data_reg;
  assign DoV = rd_vld_reg;
`endif

endmodule

// File: tb/tb_bram_sdp_be.sv
// Directed bench for bram_sdp_be: a read-first and a write-first instance
// share one stimulus stream; expected read words are queued at issue and
// checked when each instance strobes DoV.
module tb_bram_sdp_be;

  localparam int DW  = 128;
  localparam int BW  = 16;
  localparam int WLT = 1000;
  localparam int AW  = 14;
`ifdef BRAM_SDP_BE_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen = 1'b0;
  logic [BW-1:0] we  = '0;
  logic [AW-1:0] wa  = '0;
  logic [DW-1:0] di  = '0;
  logic          ren = 1'b0;
  logic [AW-1:0] ra  = '0;
  logic [DW-1:0] do_rf, do_wf;
  logic          dov_rf, dov_wf;

  always #5 clk = ~clk;

  bram_sdp_be #(.DW(DW), .WL(WLT), .RDW_MODE(0)) u_rf (
    .CLK(clk), .RST(rst), .WEN(wen), .WE(we), .WA(wa), .Di(di),
    .REN(ren), .RA(ra), .Do(do_rf), .DoV(dov_rf)
  );

  bram_sdp_be #(.DW(DW), .WL(WLT), .RDW_MODE(1)) u_wf (
    .CLK(clk), .RST(rst), .WEN(wen), .WE(we), .WA(wa), .Di(di),
    .REN(ren), .RA(ra), .Do(do_wf), .DoV(dov_wf)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] d_rf;
    logic [DW-1:0] d_wf;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mdl [WLT];
  int            cyc = 0;
  logic          rst_q = 1'b1;
  logic          mon_en = 1'b0;
  logic          exp_v = 1'b0;
  logic [DW-1:0] exp_do_rf = '0;
  logic [DW-1:0] exp_do_wf = '0;
  int            n_cmp = 0;
  int            n_bad = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] bmerge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [BW-1:0] en);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++)
      if (en[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Scoreboard: a reset edge drops everything in flight and forces Do to 0;
  // otherwise Do must hold the last completed read and DoV pulses on due cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        q.delete();
        exp_v     = 1'b0;
        exp_do_rf = '0;
        exp_do_wf = '0;
      end else begin
        exp_v = (q.size() != 0) && (q[0].due == cyc);
        if (exp_v) begin
          exp_do_rf = q[0].d_rf;
          exp_do_wf = q[0].d_wf;
          void'(q.pop_front());
        end
      end
      chk("DoV_rf", DW'(dov_rf), DW'(exp_v));
      chk("DoV_wf", DW'(dov_wf), DW'(exp_v));
      chk("Do_rf", do_rf, exp_do_rf);
      chk("Do_wf", do_wf, exp_do_wf);
      if (exp_v)
        $display("read done cyc %0d: rf=%h wf=%h", cyc, do_rf, do_wf);
    end
  end

  // One clock of stimulus; word indices are turned into byte addresses with a
  // random in-word offset, which the RAM must ignore.
  task automatic drive(input logic w_en, input logic [BW-1:0] w_be, input int w_word,
                       input logic [DW-1:0] w_data, input logic r_en, input int r_word,
                       input logic r_st);
    exp_t e;
    wen = w_en;
    we  = w_be;
    wa  = AW'((w_word << 4) + $urandom_range(0, 15));
    di  = w_data;
    ren = r_en;
    ra  = AW'((r_word << 4) + $urandom_range(0, 15));
    rst = r_st;
    if (r_en && !r_st) begin
      e.due = cyc + LAT;
      if (r_word >= WLT) begin
        e.d_rf = '0;
        e.d_wf = '0;
      end else begin
        e.d_rf = mdl[r_word];
        e.d_wf = mdl[r_word];
        if (w_en && w_word == r_word)
          e.d_wf = bmerge(mdl[r_word], w_data, w_be);
      end
      q.push_back(e);
    end
    if (w_en && !r_st && w_word < WLT)
      mdl[w_word] = bmerge(mdl[w_word], w_data, w_be);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 0, '0, 1'b0, 0, 1'b0);
  endtask

  task automatic wr(input int w, input logic [BW-1:0] be, input logic [DW-1:0] d);
    drive(1'b1, be, w, d, 1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int r);
    drive(1'b0, '0, 0, '0, 1'b1, r, 1'b0);
  endtask

  localparam logic [DW-1:0] P55   = {16{8'h55}};
  localparam logic [DW-1:0] PAA   = {16{8'hAA}};
  localparam logic [DW-1:0] PDEAD = {8{16'hDEAD}};
  localparam logic [DW-1:0] P1234 = 128'h123456789ABCDEF0_0FEDCBA987654321;
  localparam logic [DW-1:0] PC3   = 128'hC3C3_0000_1111_2222_3333_4444_5555_6666;

  initial begin
    // Reset state: monitor starts while reset is still sampled high.
    drive(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    drive(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    mon_en = 1'b1;
    drive(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    idle(2);

    // Byte-lane write at 0x20 (word 2): lower 8 bytes take 0xAA.
    wr(2, '1, P55);
    wr(2, 16'h00FF, PAA);
    rd(2);
    idle(3);

    // Collision, full mask, then read-back of the post-write word.
    wr(5, '1, PDEAD);
    drive(1'b1, '1, 5, P1234, 1'b1, 5, 1'b0);
    rd(5);
    // Collision with a partial mask.
    drive(1'b1, 16'hF0F0, 5, PC3, 1'b1, 5, 1'b0);
    rd(5);
    idle(2);

    // Write visible to a read issued on the very next cycle.
    wr(7, '1, PC3);
    rd(7);
    // WEN with empty mask is a no-op.
    wr(7, '0, PAA);
    rd(7);
    idle(2);

    // Streaming: fill words 0..15 with their index, read back-to-back.
    for (int i = 0; i < 16; i++) wr(i, '1, DW'(i));
    for (int i = 0; i < 16; i++) rd(i);
    idle(3);

    // Out-of-range word 1000: write dropped, read gives zero with DoV.
    wr(999, '1, PDEAD);
    wr(1000, '1, P1234);
    rd(1000);
    rd(999);
    idle(3);

    // Reset right after a read issue, then with a read issued under reset.
    rd(3);
    drive(1'b0, '0, 0, '0, 1'b0, 0, 1'b1);
    drive(1'b0, '0, 0, '0, 1'b1, 3, 1'b1);
    idle(3);
    rd(3);
    idle(2);

    // Write under reset must not land.
    wr(4, '1, P55);
    drive(1'b1, '1, 4, PAA, 1'b0, 0, 1'b1);
    idle(1);
    rd(4);
    // Mixed concurrent read/write stream on different words.
    for (int i = 0; i < 8; i++) drive(1'b1, 16'(16'h0F0F << i), 20 + i, {8{16'(i * 16'h1111)}}, 1'b1, i, 1'b0);
    for (int i = 0; i < 8; i++) rd(20 + i);
    idle(4);

    chk("sb_drain", DW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
